// File: rtl/pipe_stage_regs_if.sv
// Bus between the 5-stage MIPS datapath and its pipeline register chain.
// The slave side is the register chain; the master side is the surrounding datapath.
interface pipe_stage_regs_if #(
    parameter int unsigned DW = 32
);
    localparam int unsigned RW = 5;
    localparam int unsigned AW = 4;

    // IF / PC
    logic          wpcir;
    logic [DW-1:0] npc;
    logic [DW-1:0] ins;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic [DW-1:0] dins;
    logic [DW-1:0] dpc4;

    // ID decode into the chain
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic          aluimm;
    logic          shift;
    logic          jal;
    logic          regrt;
    logic [AW-1:0] aluc;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic [DW-1:0] dimm;

    // EXE
    logic          ewreg;
    logic          em2reg;
    logic          ewmem;
    logic          ealuimm;
    logic          eshift;
    logic          ejal;
    logic [AW-1:0] ealuc;
    logic [RW-1:0] edestReg;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] eimm;
    logic [DW-1:0] epc4;
    logic [DW-1:0] ealu;

    // MEM
    logic          mwreg;
    logic          mm2reg;
    logic          mwmem;
    logic [RW-1:0] mdestReg;
    logic [DW-1:0] malu;
    logic [DW-1:0] mb;
    logic [DW-1:0] mmo;

    // WB / register-file write port
    logic          wwreg;
    logic          wm2reg;
    logic [RW-1:0] wdestReg;
    logic [DW-1:0] wdi;
    logic          rf_we;

    modport master (
        output wpcir, npc, ins,
        output wreg, m2reg, wmem, aluimm, shift, jal, regrt, aluc, da, db, dimm,
        output ealu, mmo,
        input  pc, pc4, dins, dpc4,
        input  ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, edestReg,
        input  ea, eb, eimm, epc4,
        input  mwreg, mm2reg, mwmem, mdestReg, malu, mb,
        input  wwreg, wm2reg, wdestReg, wdi, rf_we
    );

    modport slave (
        input  wpcir, npc, ins,
        input  wreg, m2reg, wmem, aluimm, shift, jal, regrt, aluc, da, db, dimm,
        input  ealu, mmo,
        output pc, pc4, dins, dpc4,
        output ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, edestReg,
        output ea, eb, eimm, epc4,
        output mwreg, mm2reg, mwmem, mdestReg, malu, mb,
        output wwreg, wm2reg, wdestReg, wdi, rf_we
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers of the 5-stage MIPS core.
// wpcir stalls PC and IF/ID; the later stages always advance, so a stall becomes an EXE bubble.
module pipe_stage_regs #(
    parameter int unsigned      DW     = 32,
    parameter logic [DW-1:0]    RST_PC = '0
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_stage_regs_if.slave bus
);
    localparam int unsigned RW     = 5;
    localparam int unsigned AW     = 4;
    localparam int unsigned LINK_R = 31;

    // PC and IF/ID
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_dins;
    logic [DW-1:0] r_dpc4;
    logic [DW-1:0] w_pc4;

    // ID/EXE
    logic          r_ewreg;
    logic          r_em2reg;
    logic          r_ewmem;
    logic          r_ealuimm;
    logic          r_eshift;
    logic          r_ejal;
    logic [AW-1:0] r_ealuc;
    logic [RW-1:0] r_edest;
    logic [DW-1:0] r_ea;
    logic [DW-1:0] r_eb;
    logic [DW-1:0] r_eimm;
    logic [DW-1:0] r_epc4;
    logic [RW-1:0] w_drn;

    // EXE/MEM
    logic          r_mwreg;
    logic          r_mm2reg;
    logic          r_mwmem;
    logic [RW-1:0] r_mdest;
    logic [DW-1:0] r_malu;
    logic [DW-1:0] r_mb;

    // MEM/WB
    logic          r_wwreg;
    logic          r_wm2reg;
    logic [RW-1:0] r_wdest;
    logic [DW-1:0] r_walu;
    logic [DW-1:0] r_wmo;

    assign w_pc4 = r_pc + DW'(4);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc   <= RST_PC;
            r_dins <= '0;
            r_dpc4 <= '0;
        end else if (bus.wpcir) begin
            r_pc   <= bus.npc;
            r_dins <= bus.ins;
            r_dpc4 <= w_pc4;
        end
    end

    // Destination selection: jal links into $31, I-type writes rt, R-type writes rd.
    always_comb begin
        w_drn = r_dins[15:11];
        if (bus.jal) begin
            w_drn = RW'(LINK_R);
        end else if (bus.regrt) begin
            w_drn = r_dins[20:16];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ewreg   <= 1'b0;
            r_em2reg  <= 1'b0;
            r_ewmem   <= 1'b0;
            r_ealuimm <= 1'b0;
            r_eshift  <= 1'b0;
            r_ejal    <= 1'b0;
            r_ealuc   <= '0;
            r_edest   <= '0;
            r_ea      <= '0;
            r_eb      <= '0;
            r_eimm    <= '0;
            r_epc4    <= '0;
        end else begin
            r_ewreg   <= bus.wreg;
            r_em2reg  <= bus.m2reg;
            r_ewmem   <= bus.wmem;
            r_ealuimm <= bus.aluimm;
            r_eshift  <= bus.shift;
            r_ejal    <= bus.jal;
            r_ealuc   <= bus.aluc;
            // Non-writing slots (including stall bubbles) carry dest 0 so they never match in forwarding.
            r_edest   <= bus.wreg ? w_drn : '0;
            r_ea      <= bus.da;
            r_eb      <= bus.db;
            r_eimm    <= bus.dimm;
            r_epc4    <= r_dpc4;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mwreg  <= 1'b0;
            r_mm2reg <= 1'b0;
            r_mwmem  <= 1'b0;
            r_mdest  <= '0;
            r_malu   <= '0;
            r_mb     <= '0;
        end else begin
            r_mwreg  <= r_ewreg;
            r_mm2reg <= r_em2reg;
            r_mwmem  <= r_ewmem;
            r_mdest  <= r_edest;
            r_malu   <= bus.ealu;
            r_mb     <= r_eb;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wwreg  <= 1'b0;
            r_wm2reg <= 1'b0;
            r_wdest  <= '0;
            r_walu   <= '0;
            r_wmo    <= '0;
        end else begin
            r_wwreg  <= r_mwreg;
            r_wm2reg <= r_mm2reg;
            r_wdest  <= r_mdest;
            r_walu   <= r_malu;
            r_wmo    <= bus.mmo;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc4      = w_pc4;
    assign bus.dins     = r_dins;
    assign bus.dpc4     = r_dpc4;

    assign bus.ewreg    = r_ewreg;
    assign bus.em2reg   = r_em2reg;
    assign bus.ewmem    = r_ewmem;
    assign bus.ealuimm  = r_ealuimm;
    assign bus.eshift   = r_eshift;
    assign bus.ejal     = r_ejal;
    assign bus.ealuc    = r_ealuc;
    assign bus.edestReg = r_edest;
    assign bus.ea       = r_ea;
    assign bus.eb       = r_eb;
    assign bus.eimm     = r_eimm;
    assign bus.epc4     = r_epc4;

    assign bus.mwreg    = r_mwreg;
    assign bus.mm2reg   = r_mm2reg;
    assign bus.mwmem    = r_mwmem;
    assign bus.mdestReg = r_mdest;
    assign bus.malu     = r_malu;
    assign bus.mb       = r_mb;

    // $0 writes keep wwreg set but are masked at the register-file port.
    assign bus.wwreg    = r_wwreg;
    assign bus.wm2reg   = r_wm2reg;
    assign bus.wdestReg = r_wdest;
    assign bus.wdi      = r_wm2reg ? r_wmo : r_walu;
    assign bus.rf_we    = r_wwreg & (r_wdest != '0);
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: cycle table for the main stream plus reset and double-stall sequences.
module tb_pipe_stage_regs;
    localparam int unsigned DW = 32;

    localparam logic [31:0] I_ADD3 = 32'h0022_1820; // add  $3,$1,$2   (rt=2, rd=3)
    localparam logic [31:0] I_LW5  = 32'h8C05_0010; // lw   $5,16($0)  (rt=5)
    localparam logic [31:0] I_ADD6 = 32'h00A0_3020; // add  $6,$5,$0   (rd=6)
    localparam logic [31:0] I_JAL  = 32'h0C09_3800; // jal  with rt=9, rd=7 bit fields
    localparam logic [31:0] I_ADD0 = 32'h0022_0020; // add  $0,$1,$2

    logic clk;
    logic resetn;

    pipe_stage_regs_if #(.DW(DW)) bus ();

    pipe_stage_regs #(.DW(DW), .RST_PC(32'h0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        wpcir;
        logic [31:0] npc;
        logic [31:0] ins;
        logic        wreg;
        logic        m2reg;
        logic        regrt;
        logic        jal;
        logic [31:0] ealu;
        logic [31:0] mmo;
        logic [31:0] x_pc;
        logic [31:0] x_dins;
        logic        x_ewreg;
        logic [4:0]  x_edest;
        logic [4:0]  x_mdest;
        logic [31:0] x_malu;
        logic        x_wwreg;
        logic [4:0]  x_wdest;
        logic [31:0] x_wdi;
        logic        x_rfwe;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(
        input logic wp, input logic [31:0] npc, input logic [31:0] ins,
        input logic wreg, input logic m2reg, input logic regrt, input logic jal,
        input logic [31:0] ealu, input logic [31:0] mmo,
        input logic [31:0] pc, input logic [31:0] dins,
        input logic ew, input logic [4:0] ed, input logic [4:0] md, input logic [31:0] malu,
        input logic ww, input logic [4:0] wd, input logic [31:0] wdi, input logic rf);
        vec_t v;
        v.wpcir = wp;   v.npc = npc;     v.ins = ins;
        v.wreg = wreg;  v.m2reg = m2reg; v.regrt = regrt; v.jal = jal;
        v.ealu = ealu;  v.mmo = mmo;
        v.x_pc = pc;    v.x_dins = dins;
        v.x_ewreg = ew; v.x_edest = ed;  v.x_mdest = md;  v.x_malu = malu;
        v.x_wwreg = ww; v.x_wdest = wd;  v.x_wdi = wdi;   v.x_rfwe = rf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic wreg, input logic m2reg, input logic wmem,
                          input logic regrt, input logic jal);
        bus.wreg  = wreg;
        bus.m2reg = m2reg;
        bus.wmem  = wmem;
        bus.regrt = regrt;
        bus.jal   = jal;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        bus.wpcir = 1'b0; bus.npc = '0; bus.ins = '0;
        set_id(0, 0, 0, 0, 0);
        bus.aluimm = 1'b0; bus.shift = 1'b0; bus.aluc = '0;
        bus.da = '0; bus.db = '0; bus.dimm = '0;
        bus.ealu = '0; bus.mmo = '0;

        vecs[0] = mk(1, 32'h04, I_ADD3, 0,0,0,0, 32'h0,      32'h0,        32'h04, I_ADD3, 0, 5'd0,  5'd0,  32'h0,      0, 5'd0,  32'h0,        0);
        vecs[1] = mk(1, 32'h08, I_LW5,  1,0,0,0, 32'h0,      32'h0,        32'h08, I_LW5,  1, 5'd3,  5'd0,  32'h0,      0, 5'd0,  32'h0,        0);
        vecs[2] = mk(1, 32'h0C, I_ADD6, 1,1,1,0, 32'h1234,   32'h0,        32'h0C, I_ADD6, 1, 5'd5,  5'd3,  32'h1234,   0, 5'd0,  32'h0,        0);
        vecs[3] = mk(0, 32'h10, I_JAL,  0,0,0,0, 32'h100,    32'h0,        32'h0C, I_ADD6, 0, 5'd0,  5'd5,  32'h100,    1, 5'd3,  32'h1234,     1);
        vecs[4] = mk(1, 32'h10, I_JAL,  1,0,0,0, 32'h0,      32'hDEADBEEF, 32'h10, I_JAL,  1, 5'd6,  5'd0,  32'h0,      1, 5'd5,  32'hDEADBEEF, 1);
        vecs[5] = mk(1, 32'h14, I_ADD0, 1,0,0,1, 32'h2222,   32'h0,        32'h14, I_ADD0, 1, 5'd31, 5'd6,  32'h2222,   0, 5'd0,  32'h0,        0);
        vecs[6] = mk(1, 32'h18, 32'h0,  1,0,0,0, 32'h14,     32'h0,        32'h18, 32'h0,  1, 5'd0,  5'd31, 32'h14,     1, 5'd6,  32'h2222,     1);
        vecs[7] = mk(1, 32'h1C, 32'h0,  0,0,0,0, 32'h3333,   32'h0,        32'h1C, 32'h0,  0, 5'd0,  5'd0,  32'h3333,   1, 5'd31, 32'h14,       1);
        vecs[8] = mk(1, 32'h20, 32'h0,  0,0,0,0, 32'h0,      32'h0,        32'h20, 32'h0,  0, 5'd0,  5'd0,  32'h0,      1, 5'd0,  32'h3333,     0);

        // Mid-stream asynchronous reset after five active cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bus.wpcir = 1'b1; bus.ins = I_ADD3;
        set_id(1, 1, 1, 0, 0);
        bus.aluc = 4'h5; bus.da = 32'hA; bus.db = 32'hB; bus.dimm = 32'hC;
        bus.ealu = 32'h77; bus.mmo = 32'h99;
        for (int i = 0; i < 5; i++) begin
            bus.npc = 32'(32'h200 + 4 * i);
            tick();
        end
        chk("pre_rst_wdi",   bus.wdi,          32'h99);
        chk("pre_rst_rf_we", 32'(bus.rf_we),   32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_pc",    bus.pc,            32'h0);
        chk("rst_pc4",   bus.pc4,           32'h4);
        chk("rst_dins",  bus.dins,          32'h0);
        chk("rst_dpc4",  bus.dpc4,          32'h0);
        chk("rst_ewreg", 32'(bus.ewreg),    32'h0);
        chk("rst_ewmem", 32'(bus.ewmem),    32'h0);
        chk("rst_edest", 32'(bus.edestReg), 32'h0);
        chk("rst_ea",    bus.ea,            32'h0);
        chk("rst_eb",    bus.eb,            32'h0);
        chk("rst_ealuc", 32'(bus.ealuc),    32'h0);
        chk("rst_mwreg", 32'(bus.mwreg),    32'h0);
        chk("rst_mwmem", 32'(bus.mwmem),    32'h0);
        chk("rst_mdest", 32'(bus.mdestReg), 32'h0);
        chk("rst_malu",  bus.malu,          32'h0);
        chk("rst_mb",    bus.mb,            32'h0);
        chk("rst_wwreg", 32'(bus.wwreg),    32'h0);
        chk("rst_wdest", 32'(bus.wdestReg), 32'h0);
        chk("rst_wdi",   bus.wdi,           32'h0);
        chk("rst_rf_we", 32'(bus.rf_we),    32'h0);

        @(negedge clk);
        resetn = 1'b1;
        bus.npc = 32'h100;
        tick();
        chk("post_rst_pc", bus.pc, 32'h100);

        // Clean restart for the cycle table
        resetn = 1'b0;
        bus.aluc = '0; bus.da = '0; bus.db = '0; bus.dimm = '0;
        bus.ealu = '0; bus.mmo = '0; bus.wmem = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            bus.wpcir = vecs[i].wpcir;
            bus.npc   = vecs[i].npc;
            bus.ins   = vecs[i].ins;
            set_id(vecs[i].wreg, vecs[i].m2reg, 1'b0, vecs[i].regrt, vecs[i].jal);
            bus.ealu  = vecs[i].ealu;
            bus.mmo   = vecs[i].mmo;
            tick();
            chk($sformatf("v%0d_pc", i),    bus.pc,            vecs[i].x_pc);
            chk($sformatf("v%0d_dins", i),  bus.dins,          vecs[i].x_dins);
            chk($sformatf("v%0d_ewreg", i), 32'(bus.ewreg),    32'(vecs[i].x_ewreg));
            chk($sformatf("v%0d_edest", i), 32'(bus.edestReg), 32'(vecs[i].x_edest));
            chk($sformatf("v%0d_mdest", i), 32'(bus.mdestReg), 32'(vecs[i].x_mdest));
            chk($sformatf("v%0d_malu", i),  bus.malu,          vecs[i].x_malu);
            chk($sformatf("v%0d_wwreg", i), 32'(bus.wwreg),    32'(vecs[i].x_wwreg));
            chk($sformatf("v%0d_wdest", i), 32'(bus.wdestReg), 32'(vecs[i].x_wdest));
            chk($sformatf("v%0d_wdi", i),   bus.wdi,           vecs[i].x_wdi);
            chk($sformatf("v%0d_rf_we", i), 32'(bus.rf_we),    32'(vecs[i].x_rfwe));
            if (i == 5) begin
                chk("jal_epc4", bus.epc4, 32'h10);
                chk("jal_ejal", 32'(bus.ejal), 32'h1);
            end
        end

        // Double stall: fetch add $3, hold it two edges, then it issues exactly once
        bus.ealu = '0; bus.mmo = '0;
        bus.wpcir = 1'b1; bus.npc = 32'h24; bus.ins = I_ADD3;
        set_id(0, 0, 0, 0, 0);
        tick();
        chk("ds_fetch_pc",   bus.pc,   32'h24);
        chk("ds_fetch_dins", bus.dins, I_ADD3);

        bus.wpcir = 1'b0; bus.npc = 32'h40; bus.ins = I_LW5;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("ds_stall%0d_pc", k),    bus.pc,            32'h24);
            chk($sformatf("ds_stall%0d_dins", k),  bus.dins,          I_ADD3);
            chk($sformatf("ds_stall%0d_ewreg", k), 32'(bus.ewreg),    32'h0);
            chk($sformatf("ds_stall%0d_ewmem", k), 32'(bus.ewmem),    32'h0);
            chk($sformatf("ds_stall%0d_edest", k), 32'(bus.edestReg), 32'h0);
        end

        bus.wpcir = 1'b1; bus.ins = I_ADD6;
        set_id(1, 0, 0, 0, 0);
        tick();
        chk("ds_issue_pc",    bus.pc,            32'h40);
        chk("ds_issue_pc4",   bus.pc4,           32'h44);
        chk("ds_issue_ewreg", 32'(bus.ewreg),    32'h1);
        chk("ds_issue_edest", 32'(bus.edestReg), 32'h3);

        bus.npc = 32'h44; bus.ins = '0;
        tick();
        chk("ds_next_edest", 32'(bus.edestReg), 32'h6);
        chk("ds_next_mdest", 32'(bus.mdestReg), 32'h3);
        chk("ds_next_dins",  bus.dins,          32'h0);

        set_id(0, 0, 0, 0, 0);
        tick();
        chk("ds_drain_edest", 32'(bus.edestReg), 32'h0);
        chk("ds_drain_mdest", 32'(bus.mdestReg), 32'h6);
        chk("ds_drain_wdest", 32'(bus.wdestReg), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
